// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Size encoding, FSM states and store byte-lane mask.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_RSV = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   function automatic logic [3:0] byte_mask(
      input size_e      sz,
      input logic [1:0] off
   );
      logic [3:0] m;
      m = 4'b0000;
      unique case (sz)
         SZ_B:    m = 4'b0001 << off;
         SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
         SZ_W:    m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Valid/ready request and response channels of the MEM-stage data port.
// Master is the pipeline side, slave is the memory responder.
interface dmem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid,
      input  req_ready,
      output req_we,
      output req_size,
      output req_unsigned,
      output req_addr,
      output req_wdata,
      input  rsp_valid,
      output rsp_ready,
      input  rsp_rdata,
      input  rsp_err
   );

   modport slave (
      input  req_valid,
      output req_ready,
      input  req_we,
      input  req_size,
      input  req_unsigned,
      input  req_addr,
      input  req_wdata,
      output rsp_valid,
      input  rsp_ready,
      output rsp_rdata,
      output rsp_err
   );

endinterface

// File: rtl/dmem_load_ext.sv
// Load lane select with sign or zero extension.
// Offset is expected already aligned to the access size.
module dmem_load_ext
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  size_e       size,
   input  logic [1:0]  off,
   input  logic        uns,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;
   logic        bs;
   logic        hs;

   always_comb begin
      b    = word[{off, 3'b000} +: 8];
      h    = off[1] ? word[31:16] : word[15:0];
      bs   = b[7] & ~uns;
      hs   = h[15] & ~uns;
      data = '0;
      unique case (size)
         SZ_B:    data = {{24{bs}}, b};
         SZ_H:    data = {{16{hs}}, h};
         SZ_W:    data = word;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: accept, wait, access, hold response.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
)(
   input  logic              clk,
   input  logic              rst,
   dmem_responder_if.slave   bus
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_e      state;
   logic [3:0]  cnt;
   logic        cap_we;
   logic        cap_uns;
   size_e       cap_size;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;

   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;

   logic [31:0] mem [DEPTH_WORDS];

   logic          acc;
   logic          go;
   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic          oor;
   logic          mis;
   logic          err;
   logic [3:0]    mask;
   logic [31:0]   lane_wdata;
   logic [31:0]   rd_word;
   logic [31:0]   ld_data;

   assign bus.req_ready = (state == IDLE) && rst;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_err   = rsp_err;
   assign bus.rsp_rdata = rsp_rdata;

   assign acc = bus.req_valid && bus.req_ready;
   assign go  = (state == WAIT) && (cnt == 4'd0);
   assign idx = cap_addr[AW+1:2];
   assign oor = cap_addr[31:2] >= 30'(DEPTH_WORDS);

   // Offset is forced to the natural alignment of the size.
   always_comb begin
      off = cap_addr[1:0];
      unique case (cap_size)
         SZ_H:    off = {cap_addr[1], 1'b0};
         SZ_W:    off = 2'b00;
         default: off = cap_addr[1:0];
      endcase
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   assign mis = ((cap_size == SZ_H) && cap_addr[0]) ||
                ((cap_size == SZ_W) && (cap_addr[1:0] != 2'b00));
`else
   assign mis = 1'b0;
`endif

   assign err  = (cap_size == SZ_RSV) || oor || mis;
   assign mask = byte_mask(cap_size, off);

   always_comb begin
      lane_wdata = cap_wdata;
      unique case (cap_size)
         SZ_B:    lane_wdata = {4{cap_wdata[7:0]}};
         SZ_H:    lane_wdata = {2{cap_wdata[15:0]}};
         default: lane_wdata = cap_wdata;
      endcase
   end

   assign rd_word = mem[idx];

   dmem_load_ext u_ext (
      .word (rd_word),
      .size (cap_size),
      .off  (off),
      .uns  (cap_uns),
      .data (ld_data)
   );

   always_ff @(posedge clk) begin
      if (go && cap_we && !err) begin
         for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
               mem[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         cap_we    <= 1'b0;
         cap_uns   <= 1'b0;
         cap_size  <= SZ_B;
         cap_addr  <= '0;
         cap_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (acc) begin
                  cap_we    <= bus.req_we;
                  cap_uns   <= bus.req_unsigned;
                  cap_size  <= size_e'(bus.req_size);
                  cap_addr  <= bus.req_addr;
                  cap_wdata <= bus.req_wdata;
                  cnt       <= 4'(WAIT_CYCLES);
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (go) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= err;
                  rsp_rdata <= (err || cap_we) ? '0 : ld_data;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=1).
// Expected values are hand-computed constants.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int DW = 1024;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_responder_if bus();

   dmem_responder #(
      .DEPTH_WORDS (DW),
      .WAIT_CYCLES (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          total  = 0;
   int          passed = 0;
   int          fails  = 0;
   logic [31:0] rd;
   logic        er;
   int          lat;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd);
      int n;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic await_rsp(output int l);
      l = 0;
      do begin
         @(posedge clk);
         #1;
         l++;
      end while (!bus.rsp_valid && l < 50);
      if (!bus.rsp_valid) chk("rsp_timeout", 32'(l), 32'd0);
   endtask

   task automatic access(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] d,
                         output logic e, output int l);
      send(we, sz, uns, addr, wd);
      await_rsp(l);
      d = bus.rsp_rdata;
      e = bus.rsp_err;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = SZ_W;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      bus.rsp_ready    = 1'b1;
      rst              = 1'b0;

      #12;
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_err",   32'(bus.rsp_err),   32'd0);
      chk("rst_rdata", bus.rsp_rdata,      32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(bus.req_ready), 32'd1);

      access(1, SZ_W, 0, 32'h0, 32'h1122_3344, rd, er, lat);
      chk("sw0_err", 32'(er), 32'd0);
      access(1, SZ_W, 0, 32'hFFC, 32'h5A5A_5A5A, rd, er, lat);
      chk("sw_last_err", 32'(er), 32'd0);

      access(1, SZ_W, 0, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
      chk("sw_lat",   32'(lat), 32'd2);
      chk("sw_rdata", rd,       32'd0);
      chk("sw_err",   32'(er),  32'd0);
      access(0, SZ_W, 0, 32'h10, 32'h0, rd, er, lat);
      chk("lw_lat",   32'(lat), 32'd2);
      chk("lw_rdata", rd,       32'hDEAD_BEEF);
      chk("lw_err",   32'(er),  32'd0);

      access(1, SZ_B, 0, 32'h11, 32'h0000_0080, rd, er, lat);
      access(0, SZ_W, 0, 32'h10, 32'h0, rd, er, lat);
      chk("sb_word", rd, 32'hDEAD_80EF);
      access(0, SZ_B, 0, 32'h11, 32'h0, rd, er, lat);
      chk("lb", rd, 32'hFFFF_FF80);
      access(0, SZ_B, 1, 32'h11, 32'h0, rd, er, lat);
      chk("lbu", rd, 32'h0000_0080);

      access(1, SZ_W, 0, 32'h10, 32'h8001_BEEF, rd, er, lat);
      access(0, SZ_H, 0, 32'h12, 32'h0, rd, er, lat);
      chk("lh", rd, 32'hFFFF_8001);
      access(0, SZ_H, 1, 32'h12, 32'h0, rd, er, lat);
      chk("lhu", rd, 32'h0000_8001);
      access(1, SZ_H, 0, 32'h10, 32'hFFFF_1234, rd, er, lat);
      access(0, SZ_W, 0, 32'h10, 32'h0, rd, er, lat);
      chk("sh_word", rd, 32'h8001_1234);
      access(0, SZ_H, 0, 32'h10, 32'h0, rd, er, lat);
      chk("lh_lo", rd, 32'h0000_1234);
      access(0, SZ_B, 0, 32'h13, 32'h0, rd, er, lat);
      chk("lb_b3", rd, 32'hFFFF_FF80);
      access(0, SZ_B, 1, 32'h12, 32'h0, rd, er, lat);
      chk("lbu_b2", rd, 32'h0000_0001);

      bus.rsp_ready = 1'b0;
      send(0, SZ_W, 0, 32'h10, 32'h0);
      await_rsp(lat);
      chk("stall_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
         chk("stall_rdata", bus.rsp_rdata,      32'h8001_1234);
         chk("stall_ready", 32'(bus.req_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_valid", 32'(bus.rsp_valid), 32'd0);
      chk("hs_ready", 32'(bus.req_ready), 32'd1);

      access(0, SZ_W, 0, 32'hFFC, 32'h0, rd, er, lat);
      chk("last_rdata", rd,      32'h5A5A_5A5A);
      chk("last_err",   32'(er), 32'd0);
      access(0, SZ_W, 0, DW * 4, 32'h0, rd, er, lat);
      chk("oor_err",   32'(er), 32'd1);
      chk("oor_rdata", rd,      32'd0);
      access(0, SZ_RSV, 0, 32'h10, 32'h0, rd, er, lat);
      chk("rsv_err",   32'(er), 32'd1);
      chk("rsv_rdata", rd,      32'd0);
      access(1, SZ_W, 0, DW * 4, 32'hCAFE_F00D, rd, er, lat);
      chk("oor_sw_err", 32'(er), 32'd1);
      access(0, SZ_W, 0, 32'h0, 32'h0, rd, er, lat);
      chk("oor_sw_nowrite", rd, 32'h1122_3344);
      access(1, SZ_RSV, 0, 32'h10, 32'hCAFE_F00D, rd, er, lat);
      chk("rsv_sw_err", 32'(er), 32'd1);
      access(0, SZ_W, 0, 32'h10, 32'h0, rd, er, lat);
      chk("rsv_sw_nowrite", rd, 32'h8001_1234);

      access(0, SZ_W, 0, 32'h13, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("mis_lw_err",   32'(er), 32'd1);
      chk("mis_lw_rdata", rd,      32'd0);
`else
      chk("mis_lw_err",   32'(er), 32'd0);
      chk("mis_lw_rdata", rd,      32'h8001_1234);
`endif
      access(0, SZ_H, 0, 32'h13, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("mis_lh_err",   32'(er), 32'd1);
      chk("mis_lh_rdata", rd,      32'd0);
`else
      chk("mis_lh_err",   32'(er), 32'd0);
      chk("mis_lh_rdata", rd,      32'hFFFF_8001);
`endif

      send(1, SZ_W, 0, 32'h10, 32'h0BAD_F00D);
      rst = 1'b0;
      #1;
      chk("midrst_ready", 32'(bus.req_ready), 32'd0);
      chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("postrst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("postrst_ready", 32'(bus.req_ready), 32'd1);
      access(0, SZ_W, 0, 32'h10, 32'h0, rd, er, lat);
      chk("midrst_nowrite", rd, 32'h8001_1234);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
